// File: rtl/counter_pkg.sv
// counter_pkg: shared counter width, max value and compare FSM encoding
package counter_pkg;
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} cmp_state_t;
endpackage

// File: rtl/counter_capture_fifo.sv
// counter_capture_fifo: synchronous snapshot FIFO with valid/ready head and sticky drop flag
module counter_capture_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    input  logic             i_ovf_clr,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic r_ovf, w_full, w_pop, w_push;
    always_comb begin
        o_valid = r_wr != r_rd;
        w_full = r_wr == {~r_rd[AW], r_rd[AW-1:0]};
        w_pop = o_valid && i_ready;
        w_push = i_push && (!w_full || w_pop);
        o_data = o_valid ? r_mem[r_rd[AW-1:0]] : '0;
        o_overflow = r_ovf;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop) r_rd <= r_rd + (AW+1)'(1);
            r_ovf <= (i_push && w_full && !w_pop) || (r_ovf && !i_ovf_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/counterup10_compare_capture.sv
// counterup10_compare_capture: compare-match, wrap detect and capture FIFO on a counter bus
module counterup10_compare_capture
    import counter_pkg::*;
#(
    parameter int WIDTH     = CNT_W,
    parameter int CAP_DEPTH = 4,
    parameter bit ONE_SHOT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             cmp_load,
    input  logic [WIDTH-1:0] cmp_value,
    input  logic             cmp_disarm,
    output logic             cmp_armed,
    output logic             match,
    output logic             wrap,
    input  logic             capture_trig,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_overflow,
    input  logic             cap_ovf_clr
);
    cmp_state_t r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count_q, r_prev_q, r_cmp_reg;
    logic r_fresh, r_match, r_wrap, w_hit;
    // a stalled counter only hits on the first equal cycle, or the first armed cycle after a load
    always_comb begin
        w_hit = r_state == ARMED && r_count_q == r_cmp_reg && (r_count_q != r_prev_q || r_fresh);
        w_state_nxt = cmp_load ? ARMED
                    : (r_state == ARMED && (cmp_disarm || (w_hit && ONE_SHOT))) ? IDLE
                    : r_state;
        cmp_armed = r_state == ARMED;
        match = r_match;
        wrap = r_wrap;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count_q <= '0;
            r_prev_q <= '0;
            r_cmp_reg <= '0;
            r_fresh <= 1'b0;
            r_match <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count_q <= count;
            r_prev_q <= r_count_q;
            if (cmp_load) r_cmp_reg <= cmp_value;
            r_fresh <= cmp_load;
            r_match <= w_hit;
            r_wrap <= r_prev_q == '1 && r_count_q == '0;
        end
    end
    counter_capture_fifo #(.WIDTH(WIDTH), .DEPTH(CAP_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (capture_trig),
        .i_data    (r_count_q),
        .i_ready   (cap_ready),
        .i_ovf_clr (cap_ovf_clr),
        .o_valid   (cap_valid),
        .o_data    (cap_data),
        .o_overflow(cap_overflow)
    );
endmodule
